// File: rtl/add_pkg.sv
// Shared parameters and helpers for the registered adder slice.
package add_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CLA_BLOCK = 4;

    function automatic int group_count(input int width, input int block);
        return (width + block - 1) / block;
    endfunction

endpackage

// File: rtl/reg_adder_cla_core.sv
// Combinational block carry-lookahead adder, cin tied to 0.
module reg_adder_cla_core
    import add_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CLA_BLOCK = DEF_CLA_BLOCK
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = group_count(WIDTH, CLA_BLOCK);

    // Fully expanded in-group carries: c[j] = OR of every generate
    // chained through the propagates above it, plus cin through all of them.
    function automatic logic [CLA_BLOCK:0] expand(
        input logic [CLA_BLOCK-1:0] g,
        input logic [CLA_BLOCK-1:0] p,
        input logic                 cin
    );
        logic [CLA_BLOCK:0] c;
        logic               term;
        c    = '0;
        c[0] = cin;
        for (int j = 1; j <= CLA_BLOCK; j++) begin
            term = cin;
            for (int m = 0; m < j; m++) term = term & p[m];
            c[j] = term;
            for (int m = 0; m < j; m++) begin
                term = g[m];
                for (int k = m + 1; k < j; k++) term = term & p[k];
                c[j] = c[j] | term;
            end
        end
        return c;
    endfunction

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [NG:0]      c_grp;

    assign g_bit    = a & b;
    assign p_bit    = a ^ b;
    assign c_grp[0] = 1'b0;
    assign cout     = c_grp[NG];

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = k * CLA_BLOCK;
        localparam int SZ = (WIDTH - LO < CLA_BLOCK) ? WIDTH - LO : CLA_BLOCK;

        logic [CLA_BLOCK-1:0] gb;
        logic [CLA_BLOCK-1:0] pb;
        logic [CLA_BLOCK:0]   c_gen;
        logic [CLA_BLOCK:0]   c_in;
        logic                 grp_g;
        logic                 grp_p;

        // Partial last group: unused lanes read as kill (g=0, p=0).
        for (genvar j = 0; j < CLA_BLOCK; j++) begin : g_lane
            if (j < SZ) begin : g_live
                assign gb[j] = g_bit[LO+j];
                assign pb[j] = p_bit[LO+j];
            end else begin : g_pad
                assign gb[j] = 1'b0;
                assign pb[j] = 1'b0;
            end
        end

        assign c_gen        = expand(gb, pb, 1'b0);
        assign grp_g        = c_gen[SZ];
        assign grp_p        = &pb[SZ-1:0];
        assign c_grp[k+1]   = grp_g | (grp_p & c_grp[k]);
        assign c_in         = expand(gb, pb, c_grp[k]);

        for (genvar j = 0; j < SZ; j++) begin : g_sum
            assign sum[LO+j] = pb[j] ^ c_in[j];
        end
    end

endmodule

// File: rtl/reg_adder.sv
// Single-stage registered unsigned adder: out = in0 + in1 one cycle later.
module reg_adder
    import add_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CLA_BLOCK = DEF_CLA_BLOCK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sum;
    logic             cout_unused;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    reg_adder_cla_core #(
        .WIDTH     (WIDTH),
        .CLA_BLOCK (CLA_BLOCK)
    ) u_core (
        .a    (in0),
        .b    (in1),
        .sum  (sum),
        .cout (cout_unused)
    );

    always_comb begin
        out_d = sum;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) out_q <= '0;
        else          out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_reg_adder.sv
// Directed vectors plus random multi-width sweep for reg_adder.
module tb_reg_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in0, in1, out;
    logic [12:0] a13, b13, o13;
    logic [31:0] a32, b32, o32;
    logic [0:0]  a1, b1, o1;

    int n_pass;
    int n_total;

    reg_adder #(.WIDTH(8), .CLA_BLOCK(4)) dut (
        .clock(clock), .reset_n(reset_n), .in0(in0), .in1(in1), .out(out)
    );
    reg_adder #(.WIDTH(13), .CLA_BLOCK(5)) dut13 (
        .clock(clock), .reset_n(reset_n), .in0(a13), .in1(b13), .out(o13)
    );
    reg_adder #(.WIDTH(32), .CLA_BLOCK(4)) dut32 (
        .clock(clock), .reset_n(reset_n), .in0(a32), .in1(b32), .out(o32)
    );
    reg_adder #(.WIDTH(1), .CLA_BLOCK(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in0(a1), .in1(b1), .out(o1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0]  prev;
        logic [7:0]  e8;
        logic [12:0] e13;
        logic [31:0] e32;
        logic [0:0]  e1;

        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{8'h03, 8'h05, 8'h08};
        vecs[1] = '{8'hFF, 8'h01, 8'h00};
        vecs[2] = '{8'h80, 8'h80, 8'h00};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE};
        vecs[4] = '{8'h01, 8'h02, 8'h03};
        vecs[5] = '{8'h0A, 8'h14, 8'h1E};
        vecs[6] = '{8'h64, 8'h1B, 8'h7F};
        vecs[7] = '{8'h00, 8'h00, 8'h00};
        vecs[8] = '{8'h7F, 8'h01, 8'h80};
        vecs[9] = '{8'hFE, 8'h05, 8'h03};

        a13 = '0; b13 = '0; a32 = '0; b32 = '0; a1 = '0; b1 = '0;
        reset_n = 1'b0;
        in0 = 8'h12;
        in1 = 8'h34;
        #2;
        chk("reset_async_start", out, 8'h00);
        repeat (3) begin
            edge_wait();
            chk("reset_hold", out, 8'h00);
        end
        chk("reset_w13", o13, 13'h0);
        chk("reset_w32", o32, 32'h0);

        reset_n = 1'b1;
        prev = 8'h00;
        for (int i = 0; i < 10; i++) begin
            in0 = vecs[i].a;
            in1 = vecs[i].b;
            #3;
            chk($sformatf("hold_before_edge_%0d", i), out, prev);
            edge_wait();
            chk($sformatf("vec_%0d", i), out, vecs[i].exp);
            prev = vecs[i].exp;
        end

        in0 = 8'h40;
        in1 = 8'h01;
        edge_wait();
        chk("pre_reset_sum", out, 8'h41);
        in0 = 8'h40;
        in1 = 8'h02;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_cycle", out, 8'h00);
        edge_wait();
        chk("reset_drops_inflight", out, 8'h00);
        reset_n = 1'b1;
        in0 = 8'd7;
        in1 = 8'd9;
        #3;
        chk("post_release_before_edge", out, 8'h00);
        edge_wait();
        chk("post_release_sum", out, 8'd16);

        for (int i = 0; i < 300; i++) begin
            in0 = 8'($urandom);
            in1 = 8'($urandom);
            a13 = 13'($urandom);
            b13 = 13'($urandom);
            a32 = $urandom;
            b32 = $urandom;
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            e8  = in0 + in1;
            e13 = a13 + b13;
            e32 = a32 + b32;
            e1  = a1 + b1;
            edge_wait();
            chk("rand_w8", out, e8);
            chk("rand_w13", o13, e13);
            chk("rand_w32", o32, e32);
            chk("rand_w1", o1, e1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
